// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for one pipeline stage register.
//   master : upstream/control side; drives in_*, stall_in, flush and observes out_*, busy_*.
//   slave  : the stage register itself.
// Signals:
//   in_valid/in_data/in_keep/in_tnew/in_busy : upstream instruction and its attributes
//   stall_in : hold request; flush : replace contents with a bubble
//   out_valid/out_data/out_keep/out_tnew     : registered stage contents
//   busy_out/busy_cnt : multi-cycle occupancy indication and remaining cycles
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = 32,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned BUSY_W = 4
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic [TNEW_W-1:0] in_tnew;
  logic [BUSY_W-1:0] in_busy;
  logic              stall_in;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic [TNEW_W-1:0] out_tnew;
  logic              busy_out;
  logic [BUSY_W-1:0] busy_cnt;

  modport master (
    output in_valid, in_data, in_keep, in_tnew, in_busy, stall_in, flush,
    input  out_valid, out_data, out_keep, out_tnew, busy_out, busy_cnt
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_tnew, in_busy, stall_in, flush,
    output out_valid, out_data, out_keep, out_tnew, busy_out, busy_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register for the five-stage MIPS core.
// Provides valid bit, stall (hold), flush (bubble that keeps the side-band PC field),
// saturating Tnew countdown that keeps running while held, and a multi-cycle occupancy
// counter so an MDU-style op can hold the stage for in_busy extra cycles.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : pipe_stage_reg_if.slave (in_* / stall_in / flush in, out_* / busy_* out)
// Update priority on each clock edge: rst > flush > hold > load.
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned KEEP_W    = 32,
  parameter int unsigned TNEW_W    = 2,
  parameter int unsigned BUSY_W    = 4,
  parameter bit          DECR_TNEW = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam logic [TNEW_W-1:0] TnewOne = TNEW_W'(1);
  localparam logic [BUSY_W-1:0] BusyOne = BUSY_W'(1);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [KEEP_W-1:0] keep_q,  keep_d;
  logic [TNEW_W-1:0] tnew_q,  tnew_d;
  logic [BUSY_W-1:0] busy_q,  busy_d;
  logic              busy_nz;
  logic              hold;

  // Tnew floors at zero; with DECR_TNEW=0 it is passed through untouched.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    if (!DECR_TNEW || (x == '0)) begin
      return x;
    end
    return x - TnewOne;
  endfunction

  assign busy_nz = (busy_q != '0);
  assign hold    = bus.stall_in | busy_nz;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    tnew_d  = tnew_q;
    busy_d  = busy_q;
    if (bus.flush) begin
      // Bubble still carries the PC of the flushed slot for exception reporting.
      valid_d = 1'b0;
      data_d  = '0;
      keep_d  = bus.in_keep;
      tnew_d  = '0;
      busy_d  = '0;
    end else if (hold) begin
      // Contents frozen, but hazard and occupancy countdowns keep running.
      tnew_d = sat_dec(tnew_q);
      if (busy_nz) begin
        busy_d = busy_q - BusyOne;
      end
    end else if (bus.in_valid) begin
      valid_d = 1'b1;
      data_d  = bus.in_data;
      keep_d  = bus.in_keep;
      tnew_d  = sat_dec(bus.in_tnew);
      busy_d  = bus.in_busy;
    end else begin
      valid_d = 1'b0;
      data_d  = '0;
      keep_d  = bus.in_keep;
      tnew_d  = '0;
      busy_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      tnew_q  <= '0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      tnew_q  <= tnew_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_tnew  = tnew_q;
  assign bus.busy_cnt  = busy_q;
  assign bus.busy_out  = busy_nz;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage contents.
module tb_pipe_stage_reg;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEEP_W = 32;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned BUSY_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_stage_reg_if #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .TNEW_W (TNEW_W),
    .BUSY_W (BUSY_W)
  ) bus ();

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .KEEP_W    (KEEP_W),
    .TNEW_W    (TNEW_W),
    .BUSY_W    (BUSY_W),
    .DECR_TNEW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of what the stage holds.
  bit              m_valid;
  bit [DATA_W-1:0] m_data;
  bit [KEEP_W-1:0] m_keep;
  int              m_tnew;
  int              m_busy;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_data = '0; m_keep = '0; m_tnew = 0; m_busy = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_data = '0; m_keep = bus.in_keep; m_tnew = 0; m_busy = 0;
    end else if (bus.stall_in || m_busy > 0) begin
      m_tnew = (m_tnew > 0) ? m_tnew - 1 : 0;
      m_busy = (m_busy > 0) ? m_busy - 1 : 0;
    end else if (bus.in_valid) begin
      m_valid = 1;
      m_data  = bus.in_data;
      m_keep  = bus.in_keep;
      m_tnew  = (int'(bus.in_tnew) > 0) ? int'(bus.in_tnew) - 1 : 0;
      m_busy  = int'(bus.in_busy);
    end else begin
      m_valid = 0; m_data = '0; m_keep = bus.in_keep; m_tnew = 0; m_busy = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    128'(bus.out_valid), 128'(m_valid));
    check({tag, ".data"},     128'(bus.out_data),  128'(m_data));
    check({tag, ".keep"},     128'(bus.out_keep),  128'(m_keep));
    check({tag, ".tnew"},     128'(bus.out_tnew),  128'(m_tnew));
    check({tag, ".busy_cnt"}, 128'(bus.busy_cnt),  128'(m_busy));
    check({tag, ".busy_out"}, 128'(bus.busy_out),  128'(m_busy != 0));
  endtask

  // Advance one edge, update the model with the inputs seen at that edge, sample 1 unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                       input int t, input int b, input bit st, input bit fl);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_tnew  = TNEW_W'(t);
    bus.in_busy  = BUSY_W'(b);
    bus.stall_in = st;
    bus.flush    = fl;
  endtask

  logic [DATA_W-1:0] pat_a5;
  logic [DATA_W-1:0] pat_ff;
  logic [DATA_W-1:0] saved;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_ff = '1;
    rst = 1'b1;
    drive(0, '0, '0, 0, 0, 0, 0);
    tick("reset0");
    tick("reset1");
    check("reset_valid", 128'(bus.out_valid), 128'(0));
    check("reset_busy_out", 128'(bus.busy_out), 128'(0));
    rst = 1'b0;

    // Reset in the middle of a multi-cycle occupancy.
    drive(1, 128'h1234, 32'h100, 1, 7, 0, 0);
    tick("t1_load");
    check("t1_busy_loaded", 128'(bus.busy_cnt), 128'(7));
    drive(1, 128'h5678, 32'h104, 1, 0, 0, 0);
    tick("t1_hold1");
    tick("t1_hold2");
    rst = 1'b1;
    tick("t1_rst");
    check("t1_rst_busy_out", 128'(bus.busy_out), 128'(0));
    check("t1_rst_data", 128'(bus.out_data), 128'(0));
    rst = 1'b0;
    tick("t1_reload");
    check("t1_reload_valid", 128'(bus.out_valid), 128'(1));
    check("t1_reload_data", 128'(bus.out_data), 128'h5678);

    // Plain load with Tnew decrement.
    drive(1, pat_a5, 32'h3000, 2, 0, 0, 0);
    tick("t2_load");
    check("t2_data", 128'(bus.out_data), 128'(pat_a5));
    check("t2_keep", 128'(bus.out_keep), 128'h3000);
    check("t2_tnew1", 128'(bus.out_tnew), 128'(1));
    drive(1, pat_a5, 32'h3004, 0, 0, 0, 0);
    tick("t2_load0");
    check("t2_tnew0", 128'(bus.out_tnew), 128'(0));

    // Stall with Tnew countdown; new data ignored while held.
    drive(1, 128'hBEEF, 32'h3008, 3, 0, 0, 0);
    tick("t3_load");
    check("t3_tnew2", 128'(bus.out_tnew), 128'(2));
    drive(1, 128'hDEAD, 32'h300C, 3, 0, 1, 0);
    tick("t3_st1");
    check("t3_tnew_a", 128'(bus.out_tnew), 128'(1));
    tick("t3_st2");
    check("t3_tnew_b", 128'(bus.out_tnew), 128'(0));
    tick("t3_st3");
    check("t3_tnew_c", 128'(bus.out_tnew), 128'(0));
    check("t3_data_held", 128'(bus.out_data), 128'hBEEF);
    check("t3_keep_held", 128'(bus.out_keep), 128'h3008);
    bus.stall_in = 1'b0;
    tick("t3_release");
    check("t3_new_data", 128'(bus.out_data), 128'hDEAD);

    // Occupancy: busy_out high for 5 cycles, next instruction accepted on the 6th edge.
    drive(1, 128'h0A, 32'h4000, 0, 5, 0, 0);
    tick("t4_load");
    drive(1, 128'h0B, 32'h4004, 0, 0, 0, 0);
    for (int i = 5; i >= 1; i--) begin
      check("t4_busy_cnt", 128'(bus.busy_cnt), 128'(i));
      check("t4_busy_out", 128'(bus.busy_out), 128'(1));
      check("t4_data_held", 128'(bus.out_data), 128'h0A);
      tick("t4_hold");
    end
    check("t4_idle_cnt", 128'(bus.busy_cnt), 128'(0));
    check("t4_still_old", 128'(bus.out_data), 128'h0A);
    tick("t4_accept");
    check("t4_accepted", 128'(bus.out_data), 128'h0B);

    // Flush overrides stall and pending occupancy.
    drive(1, 128'h0C, 32'h4008, 3, 4, 0, 0);
    tick("t5_load");
    drive(1, 128'h0D, 32'h400C, 3, 0, 1, 0);
    tick("t5_hold");
    check("t5_pre_cnt", 128'(bus.busy_cnt), 128'(3));
    drive(1, 128'h0E, 32'h3010, 3, 2, 1, 1);
    tick("t5_flush");
    check("t5_valid", 128'(bus.out_valid), 128'(0));
    check("t5_tnew", 128'(bus.out_tnew), 128'(0));
    check("t5_busy_out", 128'(bus.busy_out), 128'(0));
    check("t5_keep", 128'(bus.out_keep), 128'h3010);

    // Bubble load ignores payload and in_busy.
    drive(0, pat_ff, 32'h3020, 3, 4, 0, 0);
    tick("t6_bubble");
    check("t6_data", 128'(bus.out_data), 128'(0));
    check("t6_busy", 128'(bus.busy_cnt), 128'(0));
    check("t6_keep", 128'(bus.out_keep), 128'h3020);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      saved = {$urandom, $urandom, $urandom, $urandom};
      drive(bit'($urandom_range(0, 3) != 0), saved, $urandom,
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
            bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 15) == 0));
      rst = ($urandom_range(0, 49) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
